// File: rtl/rv16_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op encodings, FSM state encoding and op classification helpers.
package rv16_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // rs1 is treated as two's complement
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as two's complement
  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // REM/REMU return the remainder instead of the quotient
  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // MULH/MULHSU/MULHU return the upper half of the product
  function automatic logic returns_high(input logic [2:0] op);
    return !op[2] && (op[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rv16_muldiv_if.sv
// Request/response bundle between the EX stage and the mul/div unit.
interface rv16_muldiv_if #(
  parameter int XLEN = 32
);
  logic            i_start;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_operand_a;
  logic [XLEN-1:0] i_operand_b;
  logic            i_kill;
  logic            o_ready;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;
  logic            o_div_by_zero;
  logic            o_overflow;

  modport master (
    output i_start, i_op, i_operand_a, i_operand_b, i_kill,
    input  o_ready, o_busy, o_done, o_result, o_div_by_zero, o_overflow
  );

  modport slave (
    input  i_start, i_op, i_operand_a, i_operand_b, i_kill,
    output o_ready, o_busy, o_done, o_result, o_div_by_zero, o_overflow
  );
endinterface

// File: rtl/rv16_div_core.sv
// Restoring divider, one quotient bit per step, on unsigned magnitudes.
// The next-step quotient/remainder are exported combinationally so the
// parent can sign-correct the final step on the same edge it is taken.
module rv16_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotient_nxt,
  output logic [XLEN-1:0] o_remainder_nxt
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   r_sh;
  logic [XLEN-1:0] diff;
  logic            fits;

  // one restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    r_sh            = {rem_q, quo_q[XLEN-1]};
    fits            = (r_sh >= {1'b0, dvs_q});
    // when the subtract is taken the true difference is below the divisor,
    // so the low XLEN bits are exact
    diff            = r_sh[XLEN-1:0] - dvs_q;
    o_remainder_nxt = fits ? diff : r_sh[XLEN-1:0];
    o_quotient_nxt  = {quo_q[XLEN-2:0], fits};
  end

  // load on accept, advance on each CALC step
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (i_load) begin
      quo_d = i_dividend;
      rem_d = '0;
      dvs_d = i_divisor;
    end else if (i_step) begin
      quo_d = o_quotient_nxt;
      rem_d = o_remainder_nxt;
    end
  end

  // divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/rv16_muldiv_unit.sv
// Iterative RV32M multiply/divide unit sitting beside the EX-stage ALU.
// Multiply is a radix-2^MUL_BPC shift-add on magnitudes with a final
// two's complement fix-up; divide lives in rv16_div_core.
// Build option: RV16_MULDIV_DIV_EN enables the divider; without it the
// divide ops complete in one cycle returning zero.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ST_IDLE | waiting for i_start
//  ST_CALC | iterating; counter counts remaining steps down to 1
//  ST_DONE | o_done high, result valid; may accept the next op
module rv16_muldiv_unit
  import rv16_muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 2
) (
  input logic           clk,
  input logic           rst_n,
  rv16_muldiv_if.slave  bus
);

  localparam int              PW         = 2 * XLEN;
  localparam int              CW         = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   MUL_CYCLES = CW'(XLEN / MUL_BPC);
  localparam logic [XLEN-1:0] MIN_VAL    = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN+MUL_BPC-1:0] mul_sum;
  logic [PW+MUL_BPC-1:0]   mul_wide;
  logic [PW-1:0]   prod_step;
  logic [PW-1:0]   prod_fin;

`ifdef RV16_MULDIV_DIV_EN
  localparam logic [CW-1:0] DIV_CYCLES = CW'(XLEN);
  logic            div_load, div_step;
  logic [XLEN-1:0] div_q_nxt, div_r_nxt;
  logic [XLEN-1:0] div_q_fin, div_r_fin;

  rv16_div_core #(.XLEN(XLEN)) u_div_core (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_load          (div_load),
    .i_step          (div_step),
    .i_dividend      (abs_a),
    .i_divisor       (abs_b),
    .o_quotient_nxt  (div_q_nxt),
    .o_remainder_nxt (div_r_nxt)
  );

  // sign fix-up of the final divide step
  always_comb begin
    div_q_fin = neg_q ? (-div_q_nxt) : div_q_nxt;
    div_r_fin = neg_q ? (-div_r_nxt) : div_r_nxt;
  end
`endif

  // operand magnitudes at accept time
  always_comb begin
    a_neg = is_signed_a(bus.i_op) & bus.i_operand_a[XLEN-1];
    b_neg = is_signed_b(bus.i_op) & bus.i_operand_b[XLEN-1];
    abs_a = a_neg ? (-bus.i_operand_a) : bus.i_operand_a;
    abs_b = b_neg ? (-bus.i_operand_b) : bus.i_operand_b;
  end

  // one multiply step: add MUL_BPC multiplier bits' worth of multiplicand
  // into the upper half, then shift the whole product right
  always_comb begin
    mul_sum   = {{MUL_BPC{1'b0}}, prod_q[PW-1:XLEN]}
              + ({{MUL_BPC{1'b0}}, mcand_q} * {{XLEN{1'b0}}, prod_q[MUL_BPC-1:0]});
    mul_wide  = {mul_sum, prod_q[XLEN-1:0]};
    prod_step = mul_wide[PW+MUL_BPC-1:MUL_BPC];
    prod_fin  = neg_q ? (-prod_step) : prod_step;
  end

  // next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    result_d = result_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
`ifdef RV16_MULDIV_DIV_EN
    div_load = 1'b0;
    div_step = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.i_kill) begin
          state_d = ST_IDLE;
        end else if (bus.i_start) begin
          op_d  = bus.i_op;
          // remainder takes the dividend's sign, everything else the product's
          neg_d = is_rem(bus.i_op) ? a_neg : (a_neg ^ b_neg);
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (is_div(bus.i_op)) begin
`ifdef RV16_MULDIV_DIV_EN
            if (bus.i_operand_b == '0) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              dbz_d    = 1'b1;
              result_d = is_rem(bus.i_op) ? bus.i_operand_a : '1;
            end else if (is_signed_b(bus.i_op) && (bus.i_operand_a == MIN_VAL) &&
                         (bus.i_operand_b == '1)) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              ovf_d    = 1'b1;
              result_d = is_rem(bus.i_op) ? '0 : MIN_VAL;
            end else begin
              state_d  = ST_CALC;
              cnt_d    = DIV_CYCLES;
              div_load = 1'b1;
            end
`else
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = '0;
`endif
          end else begin
            state_d = ST_CALC;
            cnt_d   = MUL_CYCLES;
            mcand_d = abs_a;
            prod_d  = {{XLEN{1'b0}}, abs_b};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (bus.i_kill) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (!is_div(op_q)) begin
            prod_d = prod_step;
          end
`ifdef RV16_MULDIV_DIV_EN
          div_step = is_div(op_q);
`endif
          if (cnt_q == CW'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
`ifdef RV16_MULDIV_DIV_EN
            if (is_div(op_q)) begin
              result_d = is_rem(op_q) ? div_r_fin : div_q_fin;
            end else begin
              result_d = returns_high(op_q) ? prod_fin[PW-1:XLEN] : prod_fin[XLEN-1:0];
            end
`else
            result_d = returns_high(op_q) ? prod_fin[PW-1:XLEN] : prod_fin[XLEN-1:0];
`endif
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.o_ready       = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bus.o_busy        = (state_q == ST_CALC);
  assign bus.o_done        = done_q;
  assign bus.o_result      = result_q;
  assign bus.o_div_by_zero = dbz_q;
  assign bus.o_overflow    = ovf_q;

endmodule

// File: tb/tb_rv16_muldiv_unit.sv
// Directed test of rv16_muldiv_unit at XLEN=32, MUL_BPC=2.
// Divide expectations follow RV16_MULDIV_DIV_EN as seen by this file.
module tb_rv16_muldiv_unit;
  import rv16_muldiv_pkg::*;

`ifdef RV16_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [31:0] last_res;

  rv16_muldiv_if #(.XLEN(32)) bus ();

  rv16_muldiv_unit #(.XLEN(32), .MUL_BPC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Issue one op and wait for o_done. b2b=1: caller is on the negedge of a
  // DONE cycle and the request is issued right there. poke_at>0: raise
  // i_start with other operands in that CALC cycle (must be ignored).
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat,
                        input bit exp_dbz, input bit exp_ovf,
                        input bit b2b, input int poke_at);
    int lat;
    int busy_cnt;
    if (!b2b) @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_op        = op;
    bus.i_operand_a = a;
    bus.i_operand_b = b;
    @(negedge clk);
    bus.i_start = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!bus.o_done && lat < 100) begin
      if (bus.o_busy) busy_cnt++;
      if (lat == poke_at) begin
        bus.i_start     = 1'b1;
        bus.i_op        = OP_MUL;
        bus.i_operand_a = 32'd3;
        bus.i_operand_b = 32'd4;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.i_start = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    chk({tag, ".result"}, bus.o_result, exp_res);
    chk({tag, ".div_by_zero"}, 32'(bus.o_div_by_zero), 32'(exp_dbz));
    chk({tag, ".overflow"}, 32'(bus.o_overflow), 32'(exp_ovf));
    last_res = exp_res;
  endtask

  initial begin
    int dlat;
    int done_seen;
    n_chk = 0;
    n_pass = 0;
    last_res = 32'h0;
    dlat = DIV_EN ? 33 : 1;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_op = OP_MUL;
    bus.i_operand_a = '0;
    bus.i_operand_b = '0;
    bus.i_kill = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst.ready", 32'(bus.o_ready), 32'd1);
    chk("rst.busy", 32'(bus.o_busy), 32'd0);
    chk("rst.done", 32'(bus.o_done), 32'd0);
    chk("rst.result", bus.o_result, 32'h0);
    chk("rst.dbz", 32'(bus.o_div_by_zero), 32'd0);
    chk("rst.ovf", 32'(bus.o_overflow), 32'd0);

    // multiply family
    run_op("mul", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 17, 0, 0, 0, 0);
    run_op("mulhu_b2b", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 17, 0, 0, 1, 0);
    run_op("mulh_m1", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 17, 0, 0, 0, 0);
    run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 17, 0, 0, 0, 0);
    run_op("mulh_min", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 17, 0, 0, 0, 0);

    // divide family
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32'hFFFFFFFD : 32'h0, dlat, 0, 0, 0, 0);
    run_op("rem_neg", OP_REM, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32'hFFFFFFFF : 32'h0, dlat, 0, 0, 0, 0);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'h0, dlat, 0, 0, 0, 0);
    run_op("div_negb", OP_DIV, 32'd7, 32'hFFFFFFFE, DIV_EN ? 32'hFFFFFFFD : 32'h0, dlat, 0, 0, 0, 0);
    run_op("rem_negb", OP_REM, 32'd7, 32'hFFFFFFFE, DIV_EN ? 32'd1 : 32'h0, dlat, 0, 0, 0, 0);
    run_op("divu_max", OP_DIVU, 32'hFFFFFFFF, 32'd1, DIV_EN ? 32'hFFFFFFFF : 32'h0, dlat, 0, 0, 0, 0);
    run_op("div_by0", OP_DIV, 32'd5, 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'h0, 1, DIV_EN, 0, 0, 0);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0, DIV_EN ? 32'd5 : 32'h0, 1, DIV_EN, 0, 0, 0);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 32'h80000000 : 32'h0, 1, 0, DIV_EN, 0, 0);
    run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0, DIV_EN, 0, 0);
    run_op("mul_after_skip", OP_MUL, 32'd3, 32'd4, 32'd12, 17, 0, 0, 1, 0);

    // i_start during CALC must not disturb the running op
    run_op("mul_poke", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 17, 0, 0, 0, 3);

    // kill on CALC cycle 5
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op = OP_MUL;
    bus.i_operand_a = 32'h1234;
    bus.i_operand_b = 32'h5678;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    bus.i_kill = 1'b1;
    @(negedge clk);
    bus.i_kill = 1'b0;
    chk("kill.ready", 32'(bus.o_ready), 32'd1);
    chk("kill.busy", 32'(bus.o_busy), 32'd0);
    chk("kill.result", bus.o_result, last_res);
    done_seen = 0;
    repeat (20) begin
      if (bus.o_done) done_seen++;
      @(negedge clk);
    end
    chk("kill.no_done", 32'(done_seen), 32'd0);
    run_op("mul_after_kill", OP_MUL, 32'd3, 32'd4, 32'd12, 17, 0, 0, 0, 0);

    // kill beats a simultaneous start
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_kill = 1'b1;
    bus.i_op = OP_MUL;
    bus.i_operand_a = 32'd9;
    bus.i_operand_b = 32'd9;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_kill = 1'b0;
    chk("killstart.busy", 32'(bus.o_busy), 32'd0);
    chk("killstart.done", 32'(bus.o_done), 32'd0);
    chk("killstart.result", bus.o_result, 32'd12);

    // asynchronous reset in the middle of an op
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op = OP_MUL;
    bus.i_operand_a = 32'd7;
    bus.i_operand_b = 32'hFFFFFFFD;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst.busy_before", 32'(bus.o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(bus.o_busy), 32'd0);
    chk("arst.ready", 32'(bus.o_ready), 32'd1);
    chk("arst.result", bus.o_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_after_rst", OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 17, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
